// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: packs a serial bit stream into WIDTH-bit
// words and presents them on a valid/ready output backed by a one-word buffer.
module sipo_deserializer #(
    parameter int   WIDTH     = 4,
    parameter bit   MSB_FIRST = 1'b1,
    localparam int  CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic [CW-1:0]    bit_cnt
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pvalid_q, pvalid_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] shifted;
    logic             accept;
    logic             complete;
    logic             consume;

    // The completing bit may only enter when the buffer is empty or drains now.
    assign sin_ready = !rst && !clr && !(cnt_q == LAST_BIT && pvalid_q && !pout_ready);

    assign accept   = sin_valid && sin_ready;
    assign complete = accept && (cnt_q == LAST_BIT);
    assign consume  = pvalid_q && pout_ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {sreg_q[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign shifted = {sin, sreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        sreg_d   = sreg_q;
        pout_d   = pout_q;
        pvalid_d = pvalid_q;
        cnt_d    = cnt_q;

        if (clr) begin
            sreg_d   = '0;
            cnt_d    = '0;
            pvalid_d = 1'b0;
        end else begin
            if (consume && !complete) begin
                pvalid_d = 1'b0;
            end
            if (complete) begin
                pout_d   = shifted;
                pvalid_d = 1'b1;
                sreg_d   = '0;
                cnt_d    = '0;
            end else if (accept) begin
                sreg_d = shifted;
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q   <= '0;
            pout_q   <= '0;
            pvalid_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sreg_q   <= sreg_d;
            pout_q   <= pout_d;
            pvalid_q <= pvalid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pout       = pout_q;
    assign pout_valid = pvalid_q;
    assign bit_cnt    = cnt_q;

endmodule
